// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Types and constants shared by the UART receive path and uart_transmit.
//   byte_state_e : byte-level deserialiser states
//   pair_state_e : header/payload reassembly states
//   HDR_TAG      : required upper nibble of a header byte
//   BAUD_DIV_DEFAULT : clock cycles per bit at 100 MHz / 115200 baud
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int         BAUD_DIV_DEFAULT = 868;
  localparam logic [3:0] HDR_TAG          = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } byte_state_e;

  typedef enum logic {
    WAIT_HDR,
    WAIT_PAY
  } pair_state_e;

  // A byte opens a sample pair only when its upper nibble carries the tag.
  function automatic logic is_header(input logic [7:0] b);
    return b[7:4] == HDR_TAG;
  endfunction

endpackage

// File: rtl/uart_receive_if.sv
// -----------------------------------------------------------------------------
// uart_receive_if
// Groups the serial input, its enable and the reassembled-sample outputs.
//   rx_in           : serial line, idles high (asynchronous to clk_in)
//   receive_active  : low = ignore new start bits
//   data_out        : last reassembled 12-bit sample
//   data_valid_out  : one-cycle pulse, data_out valid
//   frame_error_out : one-cycle pulse, bad stop bit or bad header tag
//   busy_out        : a byte is being received
// slave  : the receiver side (uart_receive)
// master : the board/consumer side driving rx and reading samples
// -----------------------------------------------------------------------------
interface uart_receive_if;

  logic        rx_in;
  logic        receive_active;
  logic [11:0] data_out;
  logic        data_valid_out;
  logic        frame_error_out;
  logic        busy_out;

  modport slave (
    input  rx_in,
    input  receive_active,
    output data_out,
    output data_valid_out,
    output frame_error_out,
    output busy_out
  );

  modport master (
    output rx_in,
    output receive_active,
    input  data_out,
    input  data_valid_out,
    input  frame_error_out,
    input  busy_out
  );

endinterface

// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
// 8N1 byte deserialiser: 2-flop synchroniser, start-bit validation,
// mid-bit sampling of 8 data bits (LSB first) and stop-bit check.
//   clk_in, rst_in  : clock, synchronous active-high reset
//   rx_in           : raw serial line
//   receive_active  : gates detection of new start bits only
//   byte_out        : last good byte, held
//   byte_done       : one-cycle pulse, byte_out updated
//   stop_err        : one-cycle pulse, stop bit sampled low
//   busy            : start bit detected, stop sample not yet taken
// -----------------------------------------------------------------------------
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx_in,
  input  logic       receive_active,
  output logic [7:0] byte_out,
  output logic       byte_done,
  output logic       stop_err,
  output logic       busy
);

  localparam int               CNT_W     = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);

  logic rx_meta_q, rx_s_q, rx_prev_q;
  logic rx_fall;

  byte_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Synchroniser and edge-history flops preset to the idle (high) level so
  // leaving reset never looks like a falling edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_s_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_fall && receive_active) state_d = START;
      end
      START: begin
        // Re-check the line half a bit after the edge; high means a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            done_d = 1'b1;
            byte_d = shift_q;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_out  = byte_q;
  assign byte_done = done_q;
  assign stop_err  = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: rtl/uart_receive.sv
// -----------------------------------------------------------------------------
// uart_receive
// Reassembles 12-bit samples from header {HDR_TAG, d[11:8]} + payload d[7:0]
// byte pairs arriving on an 8N1 line.
//   clk_in : 100 MHz system clock
//   rst_in : synchronous, active-high reset
//   rx_bus : uart_receive_if.slave (rx_in, receive_active, data_out,
//            data_valid_out, frame_error_out, busy_out)
// -----------------------------------------------------------------------------
module uart_receive
  import uart_pkg::*;
#(
  parameter int BAUD_DIV     = BAUD_DIV_DEFAULT,
  parameter int PAIR_TIMEOUT = 4 * 10 * BAUD_DIV
) (
  input  logic           clk_in,
  input  logic           rst_in,
  uart_receive_if.slave  rx_bus
);

  localparam int               TMO_W    = $clog2(PAIR_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PAIR_TIMEOUT - 1);

  logic [7:0] rx_byte;
  logic       byte_done;
  logic       stop_err;
  logic       byte_busy;

  uart_byte_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_byte_rx (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rx_in          (rx_bus.rx_in),
    .receive_active (rx_bus.receive_active),
    .byte_out       (rx_byte),
    .byte_done      (byte_done),
    .stop_err       (stop_err),
    .busy           (byte_busy)
  );

  pair_state_e      state_q, state_d;
  logic [3:0]       hi_nib_q, hi_nib_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [11:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= WAIT_HDR;
      hi_nib_q <= '0;
      tmo_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_nib_q <= hi_nib_d;
      tmo_q    <= tmo_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hi_nib_d = hi_nib_q;
    tmo_d    = tmo_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;

    if (stop_err) begin
      // A bad stop bit drops any pending pair; the next header restarts it.
      ferr_d  = 1'b1;
      state_d = WAIT_HDR;
    end else begin
      unique case (state_q)
        WAIT_HDR: begin
          if (byte_done) begin
            if (is_header(rx_byte)) begin
              hi_nib_d = rx_byte[3:0];
              tmo_d    = '0;
              state_d  = WAIT_PAY;
            end else begin
              ferr_d   = 1'b1;
            end
          end
        end
        WAIT_PAY: begin
          if (byte_done) begin
            // The payload carries arbitrary data, so it is never tag-checked.
            data_d  = {hi_nib_q, rx_byte};
            valid_d = 1'b1;
            state_d = WAIT_HDR;
          end else if (!byte_busy) begin
            // Only line-idle time counts towards abandoning the pair.
            if (tmo_q == TMO_LAST) state_d = WAIT_HDR;
            else                   tmo_d   = tmo_q + TMO_W'(1);
          end
        end
        default: state_d = WAIT_HDR;
      endcase
    end
  end

  assign rx_bus.data_out        = data_q;
  assign rx_bus.data_valid_out  = valid_q;
  assign rx_bus.frame_error_out = ferr_q;
  assign rx_bus.busy_out        = byte_busy;

endmodule

// File: tb/tb_uart_receive.sv
// -----------------------------------------------------------------------------
// tb_uart_receive
// Directed bench for uart_receive. A serialiser task drives 8N1 frames; the
// expected samples go into a scoreboard queue as pairs are sent, and a monitor
// pops and compares them on every data_valid_out pulse. A short bit period
// keeps the run brief; the glitch length scales with it (< BAUD/2).
// -----------------------------------------------------------------------------
module tb_uart_receive;
  import uart_pkg::*;

  localparam int BAUD   = 64;
  localparam int TMO    = 4 * 10 * BAUD;
  localparam int GLITCH = BAUD / 2 - 12;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  always #5 clk_in = ~clk_in;

  uart_receive_if u_if ();

  uart_receive #(
    .BAUD_DIV     (BAUD),
    .PAIR_TIMEOUT (TMO)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rx_bus (u_if)
  );

  int checks    = 0;
  int failures  = 0;
  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int busy_len  = 0;
  int busy_max  = 0;

  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk_in) begin
    logic [11:0] e;
    if (u_if.data_valid_out === 1'b1) begin
      valid_cnt++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
      check("data_out", {20'd0, u_if.data_out}, {20'd0, e});
    end
    if (u_if.frame_error_out === 1'b1) begin
      ferr_cnt++;
      check("err_valid_overlap", {31'd0, u_if.data_valid_out}, 32'd0);
    end
    if (u_if.busy_out === 1'b1) busy_len++;
    else                        busy_len = 0;
    if (busy_len > busy_max) busy_max = busy_len;
  end

  task automatic idle(input int n);
    u_if.rx_in = 1'b1;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    u_if.rx_in = 1'b0;
    repeat (BAUD) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      u_if.rx_in = b[i];
      repeat (BAUD) @(negedge clk_in);
    end
    u_if.rx_in = stop_bit;
    repeat (BAUD) @(negedge clk_in);
    idle(4);
  endtask

  task automatic send_pair(input logic [11:0] d);
    exp_q.push_back(d);
    send_byte({HDR_TAG, d[11:8]});
    send_byte(d[7:0]);
  endtask

  initial begin
    u_if.rx_in          = 1'b1;
    u_if.receive_active = 1'b1;
    rst_in              = 1'b1;
    repeat (5) @(negedge clk_in);
    check("rst_data_out",  {20'd0, u_if.data_out},         32'd0);
    check("rst_valid",     {31'd0, u_if.data_valid_out},   32'd0);
    check("rst_ferr",      {31'd0, u_if.frame_error_out},  32'd0);
    check("rst_busy",      {31'd0, u_if.busy_out},         32'd0);
    rst_in = 1'b0;
    idle(10);

    // Basic pair A5/3C -> 53C
    exp_q.push_back(12'h53C);
    send_byte(8'hA5);
    send_byte(8'h3C);
    check("t1_valid_cnt", valid_cnt, 1);
    check("t1_ferr_cnt",  ferr_cnt,  0);

    // Back-to-back samples, alternating and extreme patterns
    send_pair(12'hAAA);
    send_pair(12'h000);
    send_pair(12'hFFF);
    check("t2_valid_cnt", valid_cnt, 4);
    check("t2_sb_empty",  exp_q.size(), 0);

    // Wrong tag, then a good pair
    send_byte(8'h35);
    check("t3_bad_tag_err", ferr_cnt, 1);
    send_pair(12'h122);
    check("t3_valid_cnt", valid_cnt, 5);
    check("t3_data_hold", {20'd0, u_if.data_out}, 32'h122);

    // Header with stop bit low, then a lone payload (tag 1 -> tag error)
    send_byte(8'hA7, 1'b0);
    check("t4_stop_err", ferr_cnt, 2);
    send_byte(8'h11);
    check("t4_no_valid", valid_cnt, 5);
    check("t4_lone_pay_err", ferr_cnt, 3);

    // Header followed by idle beyond the pair timeout
    send_byte(8'hA9);
    idle(TMO + 10);
    send_byte(8'h44);
    check("t5_timeout_no_valid", valid_cnt, 5);
    check("t5_timeout_err", ferr_cnt, 4);
    send_pair(12'h944);
    check("t5_valid_cnt", valid_cnt, 6);

    // Idle gap well inside the timeout keeps the pair alive
    exp_q.push_back(12'h5A5);
    send_byte(8'hA5);
    idle(TMO / 2);
    send_byte(8'hA5);
    check("t5b_in_window", valid_cnt, 7);

    // Frames while receive_active is low are ignored
    busy_max = 0;
    u_if.receive_active = 1'b0;
    send_byte(8'hA5);
    u_if.receive_active = 1'b1;
    idle(BAUD);
    check("inactive_busy", busy_max, 0);
    check("inactive_valid", valid_cnt, 7);

    // Short low glitch: start rejected at the half-bit resample
    busy_max = 0;
    u_if.rx_in = 1'b0;
    repeat (GLITCH) @(negedge clk_in);
    idle(2 * BAUD);
    check("glitch_busy_len", busy_max, BAUD / 2);
    check("glitch_no_err", ferr_cnt, 4);
    check("glitch_no_valid", valid_cnt, 7);

    // Reset in the middle of a payload
    send_byte(8'hA3);
    u_if.rx_in = 1'b0;
    repeat (3 * BAUD) @(negedge clk_in);
    rst_in     = 1'b1;
    u_if.rx_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("midrst_data_out", {20'd0, u_if.data_out},        32'd0);
    check("midrst_valid",    {31'd0, u_if.data_valid_out},  32'd0);
    check("midrst_ferr",     {31'd0, u_if.frame_error_out}, 32'd0);
    check("midrst_busy",     {31'd0, u_if.busy_out},        32'd0);
    rst_in = 1'b0;
    idle(2 * BAUD);
    check("midrst_quiet_valid", valid_cnt, 7);
    check("midrst_quiet_err",   ferr_cnt,  4);
    send_pair(12'h7E1);
    check("post_rst_valid", valid_cnt, 8);
    check("final_ferr_cnt", ferr_cnt, 4);
    check("final_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_receive.md
Name: uart_receive

Overview:
- Receive-side counterpart of uart_transmit: deserialises the 8N1 UART line back into 12-bit samples on the 100 MHz fabric clock.
- Each 12-bit sample travels as two frames: header byte {4'hA, data[11:8]}, then payload byte data[7:0].
- Sits between the board RX pin and downstream sample consumers (display/logging). Emits one valid pulse per fully reassembled sample.

Parameters:
- BAUD_DIV, 868, clock cycles per UART bit (100 MHz / 115200).
- HDR_TAG, 4'hA, required upper nibble of a header byte.
- PAIR_TIMEOUT, 4*10*868, cycles allowed between header stop bit and payload start bit before the pair is abandoned.

Ports:
- clk_in  input  1  system clock, 100 MHz
- rst_in  input  1  synchronous, active-high reset
- rx_in  input  1  asynchronous serial line, idles high
- receive_active  input  1  when low, ignore new start bits; a frame already in progress completes
- data_out  output  12  last reassembled sample, held until next valid
- data_valid_out  output  1  single-cycle pulse, data_out valid this cycle
- frame_error_out  output  1  single-cycle pulse on bad stop bit or bad header tag
- busy_out  output  1  high from detected start bit until the byte's stop-bit sample

Behaviour:
- Reset (rst_in high at a clock edge): data_out=0, data_valid_out=0, frame_error_out=0, busy_out=0. Byte FSM returns to IDLE and pair FSM to WAIT_HDR. Synchroniser flops preset to 1. Reset mid-frame discards the partial byte and any held header.
- rx_in passes through a 2-flop synchroniser, rx_s, before any use. All edge detection uses rx_s.
- Byte FSM states:
  - IDLE: on rx_s falling (1->0) and receive_active=1 -> START, counter=0, busy_out=1.
  - START: at counter=BAUD_DIV/2-1, resample. If rx_s=1, treat as a glitch -> IDLE with no error. Otherwise -> DATA, bit_idx=0, counter=0.
  - DATA: sample rx_s when counter=BAUD_DIV-1 (mid-bit), shift in LSB first. After bit_idx=7 -> STOP.
  - STOP: sample at mid-bit, then busy_out=0 and -> IDLE.
    - rx_s=1: byte_done pulse with the byte.
    - rx_s=0: frame_error_out pulse, byte discarded. The FSM still returns to IDLE, and a new falling edge is required before the next start.
- Pair FSM:
  - WAIT_HDR: on byte_done with byte[7:4]==HDR_TAG, latch byte[3:0] as hi_nib and -> WAIT_PAY, timeout counter=0.
  - WAIT_HDR with byte[7:4]!=HDR_TAG: frame_error_out pulse, stay in WAIT_HDR. This resynchronises on the next header.
  - WAIT_PAY: next byte_done is taken as the payload, with no tag check. Data_out<={hi_nib, byte} and data_valid_out=1 on the cycle after byte_done, then -> WAIT_HDR.
  - WAIT_PAY timeout: the timeout counter runs while the byte FSM is IDLE. Reaching PAIR_TIMEOUT -> WAIT_HDR silently.
  - A framing error while in WAIT_PAY -> WAIT_HDR.
- Latency: data_valid_out asserts 2 cycles after the payload stop-bit mid-sample (byte_done register plus output register).
- Simultaneous events: frame_error_out and data_valid_out are never high in the same cycle. Framing errors take precedence, and that pair is dropped.
- receive_active falling during WAIT_PAY does not clear hi_nib. The timeout still applies.
- All counters are unsigned, sized $clog2 of their maximum value. No wrap is possible because every counter is cleared on each state entry.

Decomposition:
- Package uart_pkg holds:
  - byte FSM enum {IDLE, START, DATA, STOP}
  - pair FSM enum {WAIT_HDR, WAIT_PAY}
  - HDR_TAG and the default BAUD_DIV constants. uart_transmit imports the same package.
- Sub-module uart_byte_rx contains the synchroniser, byte FSM and bit counter. It outputs byte_out[7:0], byte_done and stop_err.
- uart_receive instantiates uart_byte_rx and implements the pair FSM, timeout and output registers.

Test Plan:
- Header 0xA5 then payload 0x3C, bit period 868 cycles -> exactly one data_valid_out with data_out=12'h53C, and no frame_error_out.
- uart_transmit looped back into uart_receive, sending 12'hAAA, 12'h000 and 12'hFFF in turn -> three valid pulses with matching data, in order.
- Byte 0x35 (wrong tag), then a correct 0xA1/0x22 pair -> one frame_error_out pulse, then data_out=12'h122.
- Header 0xA7 with stop bit forced 0 -> frame_error_out pulse. A following payload 0x11 alone yields no valid, because the pair FSM is still in WAIT_HDR.
- Header 0xA9, then rx_in idle for PAIR_TIMEOUT+10 cycles, then 0x44 -> no valid. A subsequent 0xA9/0x44 pair -> data_out=12'h944.
- 300-cycle low glitch on rx_in (< BAUD_DIV/2) -> no busy beyond START and no error. rst_in pulsed mid-payload -> all outputs 0, and the next full pair decodes correctly.
